// File: rtl/rx_buffer_reader.sv
// Rx packet buffer reader: streams committed packets out of the buffer RAM and returns freed space to the writer.
// Define RX_READER_LEN_CHECK_EN to drop headers whose length is zero or above MAX_LEN.
module rx_buffer_reader #(
    parameter int BF      = 9,
    parameter int MAX_LEN = 9600
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BF+1:0] commited_wr_address,
    output logic [BF:0]   rd_addr,
    output logic          rd_en,
    input  logic [63:0]   rd_data,
    output logic [BF+1:0] rd_addr_extended,
    output logic          rd_addr_change,
    output logic [63:0]   m_tdata,
    output logic [7:0]    m_tkeep,
    output logic          m_tlast,
    output logic          m_tvalid,
    input  logic          m_tready
);
    localparam int PW = BF + 2;
    localparam int AW = BF + 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA, RELEASE} state_t;

    state_t        state, state_next;
    logic [PW-1:0] sync_s0, sync_s1, commit_sync;
    logic [PW-1:0] rd_ptr, next_ptr;
    logic [AW-1:0] addr_ptr;
    logic [29:0]   issue_left, out_left;
    logic [2:0]    len_tail;
    logic          data_pending;
    logic [63:0]   fifo_mem [2];
    logic          fifo_wr_idx, fifo_rd_idx;
    logic [1:0]    fifo_count;
    logic [2:0]    ret_cnt;

    logic [31:0]   hdr_len;
    logic [29:0]   hdr_words;
    logic          hdr_bad, empty, pop, data_rd, can_issue;

`ifdef RX_READER_LEN_CHECK_EN
    (* keep *) logic [31:0] bad_len_counter;
    assign hdr_bad = (hdr_len == 32'd0) || (hdr_len > 32'(MAX_LEN));
`else
    assign hdr_bad = 1'b0;
`endif

    assign hdr_len   = rd_data[63:32];
    assign hdr_words = 30'((33'(hdr_len) + 33'd7) >> 3);
    assign empty     = (rd_ptr == commit_sync);
    assign pop       = m_tvalid && m_tready;
    // Words held plus the one in flight must leave room for the word requested now.
    assign can_issue = ({1'b0, fifo_count} + {2'b0, data_pending}) < (3'd2 + {2'b0, pop});

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        rd_addr    = rd_ptr[BF:0];
        data_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    rd_en      = 1'b1;
                    state_next = HDR;
                end
            end
            HDR: begin
                if (hdr_bad) begin
                    state_next = IDLE;
                end else if (hdr_words == 30'd0) begin
                    state_next = RELEASE;
                end else begin
                    rd_en      = 1'b1;
                    data_rd    = 1'b1;
                    rd_addr    = rd_ptr[BF:0] + AW'(1);
                    state_next = DATA;
                end
            end
            DATA: begin
                if (issue_left != 30'd0 && can_issue) begin
                    rd_en   = 1'b1;
                    data_rd = 1'b1;
                    rd_addr = addr_ptr;
                end
                if (pop && out_left == 30'd1) state_next = RELEASE;
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sync_s0      <= '0;
            sync_s1      <= '0;
            commit_sync  <= '0;
            rd_ptr       <= '0;
            next_ptr     <= '0;
            addr_ptr     <= '0;
            issue_left   <= '0;
            out_left     <= '0;
            len_tail     <= '0;
            data_pending <= 1'b0;
`ifdef RX_READER_LEN_CHECK_EN
            bad_len_counter <= '0;
`endif
        end else begin
            state        <= state_next;
            sync_s0      <= commited_wr_address;
            sync_s1      <= sync_s0;
            if (sync_s1 == sync_s0) commit_sync <= sync_s1;
            data_pending <= data_rd;
            if (state == HDR) begin
                len_tail   <= hdr_len[2:0];
                out_left   <= hdr_words;
                issue_left <= hdr_words - 30'd1;
                addr_ptr   <= rd_ptr[BF:0] + AW'(2);
                next_ptr   <= rd_ptr + PW'(hdr_words) + PW'(1);
            end else begin
                if (data_rd) begin
                    issue_left <= issue_left - 30'd1;
                    addr_ptr   <= addr_ptr + AW'(1);
                end
                if (pop) out_left <= out_left - 30'd1;
            end
            if (state == RELEASE) rd_ptr <= next_ptr;
`ifdef RX_READER_LEN_CHECK_EN
            if (state == HDR && hdr_bad) begin
                rd_ptr          <= commit_sync;
                bad_len_counter <= bad_len_counter + 32'd1;
            end
`endif
        end
    end

    // NOTE: prefetch storage has no reset; it is only visible while fifo_count says it holds data.
    always_ff @(posedge clk) begin
        if (data_pending) fifo_mem[fifo_wr_idx] <= rd_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr_idx <= 1'b0;
            fifo_rd_idx <= 1'b0;
            fifo_count  <= '0;
        end else begin
            if (data_pending) fifo_wr_idx <= ~fifo_wr_idx;
            if (pop)          fifo_rd_idx <= ~fifo_rd_idx;
            case ({data_pending, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign m_tvalid = (state == DATA) && (fifo_count != 2'd0);
    assign m_tlast  = m_tvalid && (out_left == 30'd1);
    assign m_tdata  = m_tvalid ? fifo_mem[fifo_rd_idx] : 64'd0;

    always_comb begin
        m_tkeep = 8'h00;
        if (m_tvalid) begin
            if (m_tlast && len_tail != 3'd0) m_tkeep = (8'd1 << len_tail) - 8'd1;
            else                             m_tkeep = 8'hFF;
        end
    end

    // Return window: load, strobe high for 3 cycles, then at least 3 quiet cycles before the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_cnt          <= '0;
            rd_addr_extended <= '0;
            rd_addr_change   <= 1'b0;
        end else begin
            if (ret_cnt == 3'd0) begin
                if (rd_ptr != rd_addr_extended) begin
                    rd_addr_extended <= rd_ptr;
                    ret_cnt          <= 3'd1;
                end
            end else begin
                ret_cnt <= ret_cnt + 3'd1;
            end
            rd_addr_change <= (ret_cnt >= 3'd1) && (ret_cnt <= 3'd3);
        end
    end

endmodule

// File: tb/tb_rx_buffer_reader.sv
// Directed bench for rx_buffer_reader: RAM model, stream scoreboard and pointer-return protocol monitor.
`timescale 1ns/1ps
module tb_rx_buffer_reader;
    localparam int BF = 9;
    localparam int PW = BF + 2;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] commited_wr_address;
    logic [BF:0]   rd_addr;
    logic          rd_en;
    logic [63:0]   rd_data;
    logic [PW-1:0] rd_addr_extended;
    logic          rd_addr_change;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;

    logic [63:0] ram [1024];
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          accepted = 0;
    bit          toggle_en = 1'b0;

    rx_buffer_reader #(.BF(BF), .MAX_LEN(9600)) dut (
        .clk                 (clk),
        .reset               (reset),
        .commited_wr_address (commited_wr_address),
        .rd_addr             (rd_addr),
        .rd_en               (rd_en),
        .rd_data             (rd_data),
        .rd_addr_extended    (rd_addr_extended),
        .rd_addr_change      (rd_addr_change),
        .m_tdata             (m_tdata),
        .m_tkeep             (m_tkeep),
        .m_tlast             (m_tlast),
        .m_tvalid            (m_tvalid),
        .m_tready            (m_tready)
    );

    initial forever #2 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", tag, actual, expected);
        end
    endtask

    // Header at hdr, data words hold {id, index, marker} so any misread address is visible.
    task automatic write_pkt(input int hdr, input int len, input int id, output int next);
        int w;
        w = (len + 7) / 8;
        ram[hdr % 1024] = {32'(len), 32'hFFFF_FFFF};
        for (int i = 0; i < w; i++) begin
            exp_t        e;
            logic [63:0] d;
            d = {16'(id), 16'(i), 32'hC0DE_0000 + 32'(i)};
            ram[(hdr + 1 + i) % 1024] = d;
            e.data = d;
            e.keep = (i == w - 1 && len % 8 != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF;
            e.last = (i == w - 1);
            exp_q.push_back(e);
        end
        next = (hdr + 1 + w) % 2048;
    endtask

    task automatic expect_hdr_read(input string tag, input int addr);
        int n;
        n = 0;
        while (!rd_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_hdr_seen"}, 64'(rd_en), 64'd1);
        check({tag, "_hdr_addr"}, 64'(rd_addr), 64'(addr % 1024));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (20) @(negedge clk);
    endtask

    // Tready: steady 1, or alternating 1010... when toggle_en is set.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = toggle_en ? ~m_tready : 1'b1;
        end
    end

    // Stream scoreboard and return-handshake monitor, sampled on the falling edge.
    initial begin
        exp_t          e;
        bit            stalled;
        logic [63:0]   held_data;
        logic [PW-1:0] prev_ext;
        bit            prev_change;
        int            low_run, high_run, since_load;
        stalled = 1'b0; held_data = '0; prev_ext = '0; prev_change = 1'b0;
        low_run = 100; high_run = 0; since_load = 100;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0; prev_ext = '0; prev_change = 1'b0;
                low_run = 100; high_run = 0; since_load = 100;
            end else begin
                if (stalled) begin
                    check("hold_valid", 64'(m_tvalid), 64'd1);
                    check("hold_data", m_tdata, held_data);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", m_tdata, e.data);
                        check("tkeep", 64'(m_tkeep), 64'(e.keep));
                        check("tlast", 64'(m_tlast), 64'(e.last));
                        accepted++;
                    end
                end
                stalled   = m_tvalid && !m_tready;
                held_data = m_tdata;

                if (rd_addr_extended != prev_ext) begin
                    check("ext_load_gap", 64'(low_run >= 3 && !rd_addr_change), 64'd1);
                    since_load = 0;
                end else begin
                    since_load++;
                end
                if (rd_addr_change && !prev_change) check("change_rise", 64'(since_load), 64'd1);
                if (!rd_addr_change && prev_change) check("change_width", 64'(high_run), 64'd3);
                if (rd_addr_change) begin
                    high_run++;
                    low_run = 0;
                end else begin
                    low_run++;
                    high_run = 0;
                end
                prev_ext    = rd_addr_extended;
                prev_change = rd_addr_change;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nxt, n, base;
        reset = 1'b1;
        commited_wr_address = '0;
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata", m_tdata, 64'd0);
        check("rst_tkeep", 64'(m_tkeep), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_ext", 64'(rd_addr_extended), 64'd0);
        check("rst_change", 64'(rd_addr_change), 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_empty", 64'(rd_en), 64'd0);

        // 64-byte packet at 0
        write_pkt(0, 64, 1, nxt);
        commited_wr_address = PW'(nxt);
        expect_hdr_read("t1", 0);
        n = 0;
        while (!m_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t1_latency", 64'(n), 64'd3);
        wait_drain("t1", 200);
        check("t1_ext", 64'(rd_addr_extended), 64'd9);

        // 61-byte packet at 9, partial last word
        write_pkt(9, 61, 2, nxt);
        commited_wr_address = PW'(nxt);
        expect_hdr_read("t2", 9);
        wait_drain("t2", 200);
        check("t2_ext", 64'(rd_addr_extended), 64'd18);

        // Back-to-back packets under alternating backpressure
        toggle_en = 1'b1;
        write_pkt(18, 20, 3, nxt);
        write_pkt(nxt, 37, 4, nxt);
        commited_wr_address = PW'(nxt);
        expect_hdr_read("t3", 18);
        wait_drain("t3", 400);
        toggle_en = 1'b0;
        check("t3_ext", 64'(rd_addr_extended), 64'd28);

        // Filler up to 1020, then a packet wrapping past the top of the RAM
        write_pkt(28, 7928, 5, nxt);
        commited_wr_address = PW'(nxt);
        expect_hdr_read("t4a", 28);
        wait_drain("t4a", 3000);
        check("t4a_ext", 64'(rd_addr_extended), 64'd1020);
        write_pkt(1020, 100, 6, nxt);
        commited_wr_address = PW'(nxt);
        expect_hdr_read("t4", 1020);
        wait_drain("t4", 300);
        check("t4_ext", 64'(rd_addr_extended), 64'd1034);

        // Reset in the middle of a packet
        write_pkt(1034, 64, 7, nxt);
        commited_wr_address = PW'(nxt);
        base = accepted;
        n = 0;
        while (accepted < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_mid_packet", 64'(accepted - base), 64'd2);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("t5_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("t5_rst_tdata", m_tdata, 64'd0);
        check("t5_rst_rd_en", 64'(rd_en), 64'd0);
        check("t5_rst_ext", 64'(rd_addr_extended), 64'd0);
        check("t5_rst_change", 64'(rd_addr_change), 64'd0);
        exp_q.delete();
        commited_wr_address = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_idle_rd_en", 64'(rd_en), 64'd0);
        check("t5_idle_tvalid", 64'(m_tvalid), 64'd0);

        // Three packets committed together, pointer returns coalesced
        write_pkt(0, 64, 8, nxt);
        write_pkt(nxt, 64, 9, nxt);
        write_pkt(nxt, 64, 10, nxt);
        commited_wr_address = PW'(nxt);
        expect_hdr_read("t6", 0);
        wait_drain("t6", 300);
        check("t6_ext", 64'(rd_addr_extended), 64'd27);

`ifdef RX_READER_LEN_CHECK_EN
        // Zero-length header discards everything committed
        ram[27] = {32'd0, 32'hFFFF_FFFF};
        ram[28] = 64'h1111_2222_3333_4444;
        commited_wr_address = PW'(31);
        base = accepted;
        expect_hdr_read("t7", 27);
        repeat (40) @(negedge clk);
        check("t7_no_output", 64'(accepted - base), 64'd0);
        check("t7_ext", 64'(rd_addr_extended), 64'd31);
        check("t7_bad_len", 64'(dut.bad_len_counter), 64'd1);
`else
        // Zero-length header releases one word; the following packet is streamed
        write_pkt(27, 0, 11, nxt);
        write_pkt(nxt, 8, 12, nxt);
        commited_wr_address = PW'(nxt);
        expect_hdr_read("t7", 27);
        wait_drain("t7", 200);
        check("t7_ext", 64'(rd_addr_extended), 64'd30);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
